video_line_scheduler: RTL and testbench
=======================================

VIDEO_LINE_SCHEDULER -- requirements
Module: video_line_scheduler

Interface
REQ-001 The block SHALL have parameter PIXELS, default 300, meaning pixels per active line and the width of rd_data.
REQ-002 The block SHALL have parameter LINES_ACTIVE, default 608, meaning stored lines scanned per frame.
REQ-003 The block SHALL have parameter LINES_TOTAL, default 625, meaning lines per frame including vertical blanking.
REQ-004 The block SHALL have parameters SYNC_TICKS, BP_TICKS, PIXEL_TICKS and FP_TICKS (defaults 740, 900, 7 and 260), meaning clk cycles of sync, back porch, each pixel and front porch.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: scan enable.
REQ-008 The block SHALL have port rd_addr, output, 10 bits: BRAM read line address.
REQ-009 The block SHALL have port rd_data, input, PIXELS bits: BRAM read data, valid exactly one clk after rd_addr changes; bit 0 is the leftmost pixel.
REQ-010 The block SHALL have port level, output, 2 bits: modulator level, with 0=sync, 1=blank, 2=black, 3=white.
REQ-011 The block SHALL have port line_start, output, 1 bit: one-cycle pulse on the first cycle of each SYNC.
REQ-012 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse coincident with line_start when line_cnt==0.
REQ-013 The block SHALL have port line_cnt, output, 10 bits: current line number, 0..LINES_TOTAL-1.

Function
REQ-014 The state machine SHALL have states IDLE, SYNC, BP, ACTIVE and FP.
REQ-015 In IDLE, when en=1 the block SHALL enter SYNC on the next cycle with line_cnt=0; level SHALL be 1 while in IDLE.
REQ-016 The state sequence SHALL be SYNC(SYNC_TICKS) -> BP(BP_TICKS) -> ACTIVE(PIXELS*PIXEL_TICKS) -> FP(FP_TICKS) -> SYNC; a single tick counter SHALL reload at every state change.
REQ-017 line_cnt SHALL increment on the FP->SYNC transition and wrap from LINES_TOTAL-1 to 0.
REQ-018 Lines with line_cnt>=LINES_ACTIVE are vertical blanking: SYNC for the full line except the last BP_TICKS cycles, with level=1 otherwise; no ACTIVE state is entered.
REQ-019 level SHALL be 0 in SYNC, 1 in BP and FP, and 2 or 3 in ACTIVE according to the current pixel bit (1 -> 3).
REQ-020 Fetch: on the first BP cycle of an active line, rd_addr SHALL equal line_cnt; on the second BP cycle, rd_data SHALL be captured into a PIXELS-bit shift register. This requires BP_TICKS>=2.
REQ-021 rd_addr SHALL hold between fetches; outside active lines it SHALL hold its last value.
REQ-022 In ACTIVE, the shift register SHALL shift right by one every PIXEL_TICKS cycles; the pixel output is bit 0; pixel 0 SHALL appear on the first ACTIVE cycle.
REQ-023 en=0 in any state SHALL return the block to IDLE on the next cycle, with level=1, line_cnt=0 and no pulses.
REQ-024 A late rd_data change after capture SHALL NOT affect the current line; uart writes to the current line therefore appear no earlier than the next frame.
REQ-025 Outputs SHALL be registered, with no combinational path from en or rd_data to any output.

Reset
REQ-026 While rst=1, the block SHALL be in state IDLE with level=1, rd_addr=0, line_cnt=0, line_start=0, frame_start=0, shift register 0 and tick counter 0.
REQ-027 Reset asserted mid-line SHALL take effect immediately, asynchronously; after release with en=1, a full SYNC SHALL begin on the second clk after release.

Structure
REQ-028 The level encodings (LVL_SYNC, LVL_BLANK, LVL_BLACK, LVL_WHITE) and state encodings SHALL live in the shared package video_pkg.
REQ-029 One sub-module, pixel_shifter, SHALL hold the shift register with load, shift and bit0 outputs; all timing and state logic SHALL remain in the parent.

Verification
REQ-030 The bench SHALL check timing with PIXELS=4, PIXEL_TICKS=2, SYNC=3, BP=3, FP=2 and en=1: the level sequence is 0,0,0,1,1,1, then pixels, then 1,1, for a line period of 16 cycles.
REQ-031 The bench SHALL check pixels with rd_data=4'b0101 on line 0: ACTIVE level is 3,3,2,2,3,3,2,2, and rd_addr=0 on the first BP cycle.
REQ-032 The bench SHALL check the frame structure with LINES_ACTIVE=2 and LINES_TOTAL=4: lines 2 and 3 show no level 2/3; line_cnt wraps 3->0 with frame_start=1 exactly once per 64 cycles.
REQ-033 The bench SHALL check en=0 asserted mid-ACTIVE: the next cycle shows IDLE with level=1 and line_cnt=0; re-asserting en gives line_start and frame_start on the following cycle.
REQ-034 The bench SHALL check rst pulsed mid-SYNC: outputs go to their reset values immediately, and after release SYNC restarts with a full SYNC_TICKS duration.
REQ-035 The bench SHALL check rd_data changed during ACTIVE: the pixel stream is unchanged until the next fetch.

Source files
------------

// File: rtl/video_pkg.sv
// Encodings shared by the line scheduler and its testbench:
// scheduler states and the 2-bit modulator levels.
package video_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_BP,
    ST_ACTIVE,
    ST_FP
  } state_t;

  localparam logic [1:0] LVL_SYNC  = 2'd0;
  localparam logic [1:0] LVL_BLANK = 2'd1;
  localparam logic [1:0] LVL_BLACK = 2'd2;
  localparam logic [1:0] LVL_WHITE = 2'd3;

endpackage

// File: rtl/pixel_shifter.sv
// Holds one fetched line of pixels; bit 0 is the pixel currently on screen.
module pixel_shifter #(
  parameter int WIDTH = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             bit0
);

  logic [WIDTH-1:0] sr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= data;
    end else if (shift) begin
      sr_reg <= sr_reg >> 1;
    end
  end

  assign bit0 = sr_reg[0];

endmodule

// File: rtl/video_line_scheduler.sv
// Line/frame timing generator: sequences sync, porches and active pixels,
// fetches each stored line from BRAM during back porch and drives the level.
module video_line_scheduler
  import video_pkg::*;
#(
  parameter int PIXELS       = 300,
  parameter int LINES_ACTIVE = 608,
  parameter int LINES_TOTAL  = 625,
  parameter int SYNC_TICKS   = 740,
  parameter int BP_TICKS     = 900,
  parameter int PIXEL_TICKS  = 7,
  parameter int FP_TICKS     = 260
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [9:0]        rd_addr,
  input  logic [PIXELS-1:0] rd_data,
  output logic [1:0]        level,
  output logic              line_start,
  output logic              frame_start,
  output logic [9:0]        line_cnt
);

  localparam int ACT_TICKS  = PIXELS * PIXEL_TICKS;
  localparam int LINE_TICKS = SYNC_TICKS + BP_TICKS + ACT_TICKS + FP_TICKS;
  localparam int TW         = $clog2(LINE_TICKS);
  localparam int PW         = (PIXEL_TICKS > 1) ? $clog2(PIXEL_TICKS) : 1;

  // Tick counter counts down from duration-1; zero marks the last cycle of a state.
  localparam logic [TW-1:0] SYNC_LD    = TW'(SYNC_TICKS - 1);
  localparam logic [TW-1:0] BSYNC_LD   = TW'(LINE_TICKS - BP_TICKS - 1);
  localparam logic [TW-1:0] BP_LD      = TW'(BP_TICKS - 1);
  localparam logic [TW-1:0] ACT_LD     = TW'(ACT_TICKS - 1);
  localparam logic [TW-1:0] FP_LD      = TW'(FP_TICKS - 1);
  localparam logic [TW-1:0] FETCH_TICK = TW'(BP_TICKS - 2);
  localparam logic [PW-1:0] PIX_LAST   = PW'(PIXEL_TICKS - 1);
  localparam logic [9:0]    LA_LIM     = 10'(LINES_ACTIVE);
  localparam logic [9:0]    LT_LAST    = 10'(LINES_TOTAL - 1);

  state_t          state_reg, state_next;
  logic [TW-1:0]   tick_reg, tick_next;
  logic [PW-1:0]   pix_reg, pix_next;
  logic [9:0]      line_reg, line_next;
  logic [9:0]      addr_reg, addr_next;
  logic [9:0]      line_inc;
  logic            line_start_reg, line_start_next;
  logic            frame_start_reg, frame_start_next;
  logic            load, shift, start_line, pixel, blank;

  assign blank    = (line_reg >= LA_LIM);
  assign line_inc = (line_reg == LT_LAST) ? 10'd0 : line_reg + 10'd1;

  pixel_shifter #(.WIDTH(PIXELS)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .data  (rd_data),
    .bit0  (pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      tick_reg        <= '0;
      pix_reg         <= '0;
      line_reg        <= '0;
      addr_reg        <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tick_reg        <= tick_next;
      pix_reg         <= pix_next;
      line_reg        <= line_next;
      addr_reg        <= addr_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    tick_next        = tick_reg - 1'b1;
    pix_next         = pix_reg;
    line_next        = line_reg;
    addr_next        = addr_reg;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;
    load             = 1'b0;
    shift            = 1'b0;
    start_line       = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
      tick_next  = '0;
      pix_next   = '0;
      line_next  = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next       = ST_SYNC;
          tick_next        = SYNC_LD;
          line_next        = '0;
          line_start_next  = 1'b1;
          frame_start_next = 1'b1;
        end
        ST_SYNC: begin
          if (tick_reg == '0) begin
            state_next = ST_BP;
            tick_next  = BP_LD;
            if (!blank) addr_next = line_reg;
          end
        end
        ST_BP: begin
          // BRAM data for the address set on BP entry is valid on the second BP cycle.
          load = !blank && (tick_reg == FETCH_TICK);
          if (tick_reg == '0) begin
            if (blank) begin
              start_line = 1'b1;
            end else begin
              state_next = ST_ACTIVE;
              tick_next  = ACT_LD;
              pix_next   = '0;
            end
          end
        end
        ST_ACTIVE: begin
          shift    = (pix_reg == PIX_LAST);
          pix_next = shift ? '0 : pix_reg + 1'b1;
          if (tick_reg == '0) begin
            state_next = ST_FP;
            tick_next  = FP_LD;
          end
        end
        ST_FP: begin
          if (tick_reg == '0) start_line = 1'b1;
        end
        default: begin
          state_next = ST_IDLE;
          tick_next  = '0;
        end
      endcase
      if (start_line) begin
        state_next       = ST_SYNC;
        line_next        = line_inc;
        tick_next        = (line_inc >= LA_LIM) ? BSYNC_LD : SYNC_LD;
        line_start_next  = 1'b1;
        frame_start_next = (line_inc == 10'd0);
      end
    end
  end

  // Level is decoded from flops only (state register and shifter bit 0).
  always_comb begin
    level = LVL_BLANK;
    case (state_reg)
      ST_SYNC:   level = LVL_SYNC;
      ST_ACTIVE: level = pixel ? LVL_WHITE : LVL_BLACK;
      default:   level = LVL_BLANK;
    endcase
  end

  assign rd_addr     = addr_reg;
  assign line_cnt    = line_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_video_line_scheduler.sv
// Self-checking bench: a line-position model predicts every output each cycle,
// plus literal checks of line timing, pixels, frame wrap, en drop and reset.
module tb_video_line_scheduler;

  localparam int PIX    = 4;
  localparam int LA     = 2;
  localparam int LT     = 4;
  localparam int SYNC   = 3;
  localparam int BP     = 3;
  localparam int PT     = 2;
  localparam int FP     = 2;
  localparam int ACT    = PIX * PT;
  localparam int PERIOD = SYNC + BP + ACT + FP;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic [9:0]     rd_addr;
  logic [PIX-1:0] rd_data = '0;
  logic [1:0]     level;
  logic           line_start, frame_start;
  logic [9:0]     line_cnt;

  logic [PIX-1:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  video_line_scheduler #(
    .PIXELS(PIX), .LINES_ACTIVE(LA), .LINES_TOTAL(LT),
    .SYNC_TICKS(SYNC), .BP_TICKS(BP), .PIXEL_TICKS(PT), .FP_TICKS(FP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
    .level(level), .line_start(line_start), .frame_start(frame_start),
    .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  // BRAM with one-cycle registered read
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: running flag, cycle position within the line, line number,
  // last fetched address and the pixel snapshot captured for the current line.
  bit       m_run  = 1'b0;
  int       m_pos  = 0;
  int       m_line = 0;
  int       m_addr = 0;
  logic [PIX-1:0] m_cap = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_line = 0; m_addr = 0;
    end else if (!en) begin
      m_run = 1'b0; m_line = 0;
    end else begin
      if (!m_run) begin
        m_run = 1'b1; m_pos = 0; m_line = 0;
      end else begin
        m_pos++;
        if (m_pos == PERIOD) begin
          m_pos  = 0;
          m_line = (m_line + 1) % LT;
        end
      end
      if (m_line < LA && m_pos == SYNC)     m_addr = m_line;
      if (m_line < LA && m_pos == SYNC + 1) m_cap  = mem[m_addr];
    end
  end

  function automatic int exp_level();
    if (!m_run) return 1;
    if (m_line >= LA) return (m_pos < PERIOD - BP) ? 0 : 1;
    if (m_pos < SYNC) return 0;
    if (m_pos < SYNC + BP) return 1;
    if (m_pos < SYNC + BP + ACT) return m_cap[(m_pos - SYNC - BP) / PT] ? 3 : 2;
    return 1;
  endfunction

  function automatic bit in_active();
    return m_run && m_line < LA && m_pos >= SYNC + BP && m_pos < SYNC + BP + ACT;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("level", int'(level), exp_level());
      chk("line_start", int'(line_start), (m_run && m_pos == 0) ? 1 : 0);
      chk("frame_start", int'(frame_start), (m_run && m_pos == 0 && m_line == 0) ? 1 : 0);
      chk("line_cnt", int'(line_cnt), m_line);
      chk("rd_addr", int'(rd_addr), m_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lv [0:15];
    int exp_line [0:15] = '{0,0,0,1,1,1,3,3,2,2,3,3,2,2,1,1};
    int exp_pix  [0:7]  = '{3,3,2,2,3,3,2,2};
    int fs_count, blank_px, w, n;
    int lc_prev;

    for (int i = 0; i < 1024; i++) mem[i] = PIX'($urandom);
    mem[0] = 4'b0101;
    mem[1] = 4'b0011;

    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_level", int'(level), 1);
    chk("reset_line_cnt", int'(line_cnt), 0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_line_start", int'(line_start), 0);
    $display("reset state checked");

    rst = 1'b0;
    en  = 1'b1;
    fs_count = 0;
    blank_px = 0;
    lc_prev  = 0;
    for (int c = 0; c < 88; c++) begin
      @(negedge clk);
      if (c < 16) lv[c] = int'(level);
      if (c == 0) chk("first_line_start", int'(line_start), 1);
      if (c == 3) chk("rd_addr_line0", int'(rd_addr), 0);
      if (c == 19) chk("rd_addr_line1", int'(rd_addr), 1);
      if (c >= 16 && c < 80 && frame_start) fs_count++;
      if (c >= 32 && c < 64 && level >= 2'd2) blank_px++;
      if (c == 64) begin
        chk("wrap_prev_line", lc_prev, 3);
        chk("wrap_line", int'(line_cnt), 0);
      end
      if (c >= 70 && c < 78) chk("pixel_hold", int'(level), exp_pix[c - 70]);
      if (c == 70) mem[0] = 4'b1010;
      lc_prev = int'(line_cnt);
      if (c == 87) en = 1'b0;
    end
    for (int i = 0; i < 16; i++) chk("line_level", lv[i], exp_line[i]);
    chk("frame_start_per_frame", fs_count, 1);
    chk("blank_line_pixels", blank_px, 0);
    $display("line timing, pixels, frame wrap and late rd_data checked");

    @(negedge clk);
    chk("en_off_level", int'(level), 1);
    chk("en_off_line_cnt", int'(line_cnt), 0);
    chk("en_off_line_start", int'(line_start), 0);
    chk("en_off_frame_start", int'(frame_start), 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_on_line_start", int'(line_start), 1);
    chk("en_on_frame_start", int'(frame_start), 1);
    $display("en drop mid-active checked");

    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_level", int'(level), 1);
    chk("rst_line_cnt", int'(line_cnt), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_line_start", int'(line_start), 0);
    #1 rst = 1'b0;
    w = 0;
    while (line_start !== 1'b1 && w < 5) begin
      @(negedge clk);
      w++;
    end
    chk("restart_line_start", int'(line_start), 1);
    n = 0;
    while (level == 2'd0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("restart_sync_len", n, SYNC);
    $display("reset mid-sync checked");

    repeat (3000) begin
      @(negedge clk);
      en = ($urandom_range(0, 63) != 0);
      if (in_active() && $urandom_range(0, 3) == 0)
        mem[$urandom_range(0, 3)] = PIX'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    en = 1'b1;
    repeat (70) @(negedge clk);
    $display("random phase done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
